// File: rtl/ringosc_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronised rising edges of osc_in over a GATE_CYCLES window.
// Define RINGOSC_STUCK_DETECT_EN to flag a zero-edge window on the stuck output.
module ringosc_freq_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             overflow,
  output logic             stuck
);

  localparam int TMR_W  = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam int WARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(GATE_CYCLES - 1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {IDLE, GATE, HOLD} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_prev;
  logic [WARM_W-1:0]      r_warm;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt, r_cnt_out;
  logic [TMR_W-1:0]       r_timer;
  logic                   r_ovf;
  logic                   w_edge, w_sat, w_last, w_start_acc, w_busy, w_valid;

  // Edge detection stays masked until the cleared chain and the previous-value flop
  // both hold real oscillator samples, so reset cannot fake a 0->1 transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync      <= '0;
      r_sync_prev <= 1'b0;
      r_warm      <= '0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], osc_in};
      r_sync_prev <= r_sync[SYNC_STAGES-1];
      if (r_warm != WARM_DONE) r_warm <= r_warm + WARM_W'(1);
    end
  end

  assign w_edge    = r_sync[SYNC_STAGES-1] & ~r_sync_prev & (r_warm == WARM_DONE);
  assign w_sat     = (r_cnt == CNT_MAX);
  assign w_cnt_nxt = (w_edge && !w_sat) ? r_cnt + CNT_W'(1) : r_cnt;
  assign w_last    = (r_timer == TMR_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_valid     = 1'b0;
    w_start_acc = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = GATE;
          w_start_acc = 1'b1;
        end
      end
      GATE: begin
        w_busy = 1'b1;
        if (w_last) w_state_nxt = HOLD;
      end
      HOLD: begin
        w_valid = 1'b1;
        if (cnt_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // The final-cycle edge is folded into the latched result via w_cnt_nxt.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_timer   <= '0;
      r_ovf     <= 1'b0;
      r_cnt_out <= '0;
    end else if (w_start_acc) begin
      r_cnt   <= '0;
      r_timer <= '0;
      r_ovf   <= 1'b0;
    end else if (r_state == GATE) begin
      r_cnt   <= w_cnt_nxt;
      r_timer <= r_timer + TMR_W'(1);
      if (w_edge && w_sat) r_ovf <= 1'b1;
      if (w_last) r_cnt_out <= w_cnt_nxt;
    end
  end

  assign busy      = w_busy;
  assign cnt_valid = w_valid;
  assign cnt_out   = r_cnt_out;
  assign overflow  = r_ovf;

`ifdef RINGOSC_STUCK_DETECT_EN
  assign stuck = w_valid && (r_cnt_out == '0);
`else
  assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_ringosc_freq_meter.sv
// Bench for ringosc_freq_meter: timeline/edge-count model checked every cycle plus directed literal checks.
module tb_ringosc_freq_meter;

  localparam int G    = 100;
  localparam int W    = 4;
  localparam int S    = 2;
  localparam int CMAX = (1 << W) - 1;
`ifdef RINGOSC_STUCK_DETECT_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, osc, start, cnt_ready;
  logic         busy, cnt_valid, overflow, stuck;
  logic [W-1:0] cnt_out;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int osc_per = 0;
  bit osc_lvl = 1'b0;
  int osc_ph  = 0;
  bit osc_hist [0:8191];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ringosc_freq_meter #(.GATE_CYCLES(G), .CNT_W(W), .SYNC_STAGES(S)) u_dut (
    .clk(clk), .rst(rst), .osc_in(osc), .start(start), .busy(busy),
    .cnt_out(cnt_out), .cnt_valid(cnt_valid), .cnt_ready(cnt_ready),
    .overflow(overflow), .stuck(stuck)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Oscillator: square wave of osc_per clk cycles, or a constant level when osc_per is 0.
  initial begin
    osc = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (osc_per == 0) osc = osc_lvl;
      else begin
        osc_ph = (osc_ph + 1) % osc_per;
        osc    = (osc_ph < osc_per / 2);
      end
    end
  end

  // Model: a start accepted in cycle s gives busy in s+1..s+G and valid from s+G+1 to the
  // handshake cycle; the result counts osc rising transitions whose synchronised pulse
  // (S cycles later) lands inside the busy window, saturating at CMAX.
  int m_s   = 0;
  int m_h   = 0;
  bit m_act = 1'b0;
  bit m_en  = 1'b0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;

  always @(negedge clk) begin : model
    int n, raw;
    bit eb, ev;
    n = cyc;
    osc_hist[n] = osc;
    eb = m_act && (n >= m_s + 1) && (n <= m_s + G);
    ev = m_act && (n >= m_s + G + 1) && (n <= m_h);
    if (m_act && n == m_s + G + 1) begin
      raw = 0;
      for (int k = m_s + 1 - S; k <= m_s + G - S; k++)
        if (osc_hist[k] && !osc_hist[k-1]) raw++;
      m_cnt = (raw > CMAX) ? CMAX : raw;
      m_ovf = (raw > CMAX);
    end
    if (m_en) begin
      chk("model_busy", 32'(busy), 32'(eb));
      chk("model_valid", 32'(cnt_valid), 32'(ev));
      if (!eb) begin
        chk("model_cnt", 32'(cnt_out), 32'(m_cnt));
        chk("model_ovf", 32'(overflow), 32'(m_ovf));
      end
      chk("model_stuck", 32'(stuck), 32'(STUCK_EN && ev && m_cnt == 0));
    end
    if (rst) begin
      m_act = 1'b0;
      m_cnt = 0;
      m_ovf = 1'b0;
      m_en  = 1'b1;
    end else if (ev && cnt_ready) begin
      m_h = n;
    end else if (start && !eb && !ev) begin
      m_act = 1'b1;
      m_s   = n;
      m_h   = 32'h7fff_ffff;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; cnt_ready = 1'b0;
    tick(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(cnt_valid), 0);
    chk("rst_cnt", 32'(cnt_out), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_stuck", 32'(stuck), 0);
    rst = 1'b0;
    tick(10);

    // Period 10: 10 edges, extra starts in GATE and HOLD ignored, held result, start in handshake ignored
    osc_per = 10;
    tick(20);
    start = 1'b1; tick(1); start = 1'b0;
    chk("t1_busy_first", 32'(busy), 1);
    tick(39);
    start = 1'b1; tick(1); start = 1'b0;
    tick(G - 41);
    chk("t1_busy_last", 32'(busy), 1);
    chk("t1_valid_early", 32'(cnt_valid), 0);
    tick(1);
    chk("t1_valid", 32'(cnt_valid), 1);
    chk("t1_busy_off", 32'(busy), 0);
    chk("t1_cnt", 32'(cnt_out), 10);
    chk("t1_ovf", 32'(overflow), 0);
    tick(4);
    start = 1'b1; tick(1); start = 1'b0;
    tick(45);
    chk("t1_valid_held", 32'(cnt_valid), 1);
    chk("t1_cnt_held", 32'(cnt_out), 10);
    cnt_ready = 1'b1; start = 1'b1; tick(1); cnt_ready = 1'b0; start = 1'b0;
    chk("t1_valid_drop", 32'(cnt_valid), 0);
    chk("t1_busy_idle", 32'(busy), 0);
    tick(3);
    chk("t1_hs_start_ignored", 32'(busy), 0);

    // Period 4 into a 4-bit counter: saturation and overflow, then a stuck-low window
    osc_per = 4;
    tick(10);
    start = 1'b1; tick(1); start = 1'b0;
    tick(G);
    chk("t2_valid", 32'(cnt_valid), 1);
    chk("t2_cnt_sat", 32'(cnt_out), 15);
    chk("t2_ovf", 32'(overflow), 1);
    osc_per = 0; osc_lvl = 1'b0;
    cnt_ready = 1'b1; tick(1); cnt_ready = 1'b0;
    tick(10);
    start = 1'b1; tick(1); start = 1'b0;
    chk("t2_ovf_cleared", 32'(overflow), 0);
    tick(G);
    chk("t2_stuck_valid", 32'(cnt_valid), 1);
    chk("t2_stuck_cnt", 32'(cnt_out), 0);
    chk("t2_stuck", 32'(stuck), 32'(STUCK_EN));
    cnt_ready = 1'b1; tick(1); cnt_ready = 1'b0;
    chk("t2_stuck_clear", 32'(stuck), 0);

    // Reset 40 cycles into a window aborts it; a fresh start then measures fully
    osc_per = 10;
    tick(10);
    start = 1'b1; tick(1); start = 1'b0;
    tick(39);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("t3_abort_busy", 32'(busy), 0);
    chk("t3_abort_valid", 32'(cnt_valid), 0);
    tick(10);
    start = 1'b1; tick(1); start = 1'b0;
    tick(G);
    chk("t3_valid", 32'(cnt_valid), 1);
    chk("t3_cnt", 32'(cnt_out), 10);
    cnt_ready = 1'b1; tick(1); cnt_ready = 1'b0;

    // osc held high through reset, start right after: the cleared chain must not add an edge
    osc_per = 0; osc_lvl = 1'b1;
    tick(10);
    rst = 1'b1; tick(1); rst = 1'b0;
    start = 1'b1; tick(1); start = 1'b0;
    tick(G);
    chk("t4_valid", 32'(cnt_valid), 1);
    chk("t4_cnt_no_spurious", 32'(cnt_out), 0);
    cnt_ready = 1'b1; tick(1); cnt_ready = 1'b0;
    tick(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ringosc_freq_meter.md
RINGOSC_FREQ_METER -- requirements
Module: ringosc_freq_meter

Interface
REQ-001 The block SHALL accept parameter GATE_CYCLES, default 1000: length of the measurement window in clk cycles, legal range 2 to 2^20.
REQ-002 The block SHALL accept parameter CNT_W, default 16: width of the edge counter and of cnt_out.
REQ-003 The block SHALL accept parameter SYNC_STAGES, default 2: number of synchroniser flops on osc_in, legal range 2 to 4.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk in, 1 bit, sole clock, rising edge.
REQ-005 rst in 1: synchronous active-high reset.
REQ-006 osc_in in 1: free-running ring-oscillator output (e.g. net n1 of the inverter ring), asynchronous to clk.
REQ-007 start in 1: request one measurement.
REQ-008 busy out 1: high while a measurement is in progress.
REQ-009 cnt_out out CNT_W: rising-edge count for the last window.
REQ-010 cnt_valid out 1: result available.
REQ-011 cnt_ready in 1: consumer accepts the result.
REQ-012 overflow out 1: count saturated during the window.
REQ-013 stuck out 1: no edge seen during the window.

Function
REQ-014 osc_in SHALL pass through SYNC_STAGES flops; a rising edge SHALL be detected as sync output 1 with the previous sync output 0, giving one pulse per edge.
REQ-015 Edges from oscillator periods shorter than 2 clk periods alias; the block SHALL NOT compensate for this.
REQ-016 FSM states SHALL be IDLE, GATE and HOLD, and each transition SHALL take effect on the next clk edge.
REQ-017 IDLE with start=1 SHALL go to GATE, clearing the edge counter, the window timer and overflow.
REQ-018 Outside IDLE, start SHALL be ignored.
REQ-019 In GATE, the timer SHALL count 0 to GATE_CYCLES-1, and each detected edge SHALL increment the counter, including an edge on the final window cycle.
REQ-020 The counter SHALL saturate at 2^CNT_W-1, and a further edge SHALL set overflow, which stays set until the next accepted start.
REQ-021 After the final window cycle, the FSM SHALL go to HOLD, latch cnt_out and assert cnt_valid.
REQ-022 Latency: if start is sampled at cycle 0, busy SHALL be high for cycles 1 to GATE_CYCLES and cnt_valid SHALL first be high at cycle GATE_CYCLES+1.
REQ-023 In HOLD, cnt_out, overflow and stuck SHALL be stable and cnt_valid SHALL be held until a cycle with cnt_valid=1 and cnt_ready=1, after which the FSM goes to IDLE and cnt_valid drops.
REQ-024 start asserted in that handshake cycle SHALL be ignored.
REQ-025 busy SHALL be high in GATE only.
REQ-026 Edges arriving in IDLE or HOLD SHALL NOT be counted.
REQ-027 The synchroniser SHALL keep running in all states.

Reset
REQ-028 When rst=1 at a clk edge, the FSM SHALL go to IDLE, and all synchroniser flops, the counter and the timer SHALL clear to 0.
REQ-029 On that same reset, cnt_out, cnt_valid, busy, overflow and stuck SHALL all clear to 0.
REQ-030 rst SHALL take priority over start and over the handshake.
REQ-031 Reset during GATE or HOLD SHALL abort the measurement and discard its result.
REQ-032 After rst is released, no spurious edge SHALL be counted from the cleared synchroniser.

Configuration
REQ-033 The feature SHALL be controlled by the macro RINGOSC_STUCK_DETECT_EN.
REQ-034 With the macro defined, stuck SHALL be set in HOLD when the latched count is 0, be valid together with cnt_valid, and clear on leaving HOLD.
REQ-035 Without the macro, the stuck port SHALL remain and be tied to 0, with no detection logic.

Verification
REQ-036 GATE_CYCLES=100, osc_in period 10 clk, one start -> cnt_valid at cycle 101, cnt_out=10 (±1), overflow=0.
REQ-037 cnt_ready held low 50 cycles after cnt_valid -> cnt_valid stays 1, cnt_out unchanged; cnt_ready=1 -> cnt_valid=0 next cycle, busy=0.
REQ-038 CNT_W=4, GATE_CYCLES=100, osc period 4 clk -> cnt_out=15, overflow=1; next start clears overflow.
REQ-039 osc_in held 0, GATE_CYCLES=50 -> cnt_out=0; stuck=1 with RINGOSC_STUCK_DETECT_EN, stuck=0 without.
REQ-040 rst pulsed at cycle 40 of a 100-cycle window -> next cycle busy=0, cnt_valid=0; a fresh start gives a full, correct count.
REQ-041 start re-pulsed during GATE and during HOLD -> no restart, result and latency as in REQ-036.
